// File: rtl/priority_encoder_stream.sv
// Priority encoder with a registered one-shot encode result and a serial,
// back-pressured stream of the word's set-bit positions.
module priority_encoder_stream #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned IDX_W = $clog2(WIDTH)
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic [WIDTH-1:0]  data_i,
    input  logic              data_val_i,
    input  logic              msb_first_i,
    output logic              data_ready_o,
    output logic              enc_val_o,
    output logic [WIDTH-1:0]  data_left_o,
    output logic [WIDTH-1:0]  data_right_o,
    output logic [IDX_W-1:0]  left_idx_o,
    output logic [IDX_W-1:0]  right_idx_o,
    output logic [IDX_W:0]    cnt_o,
    output logic              zero_o,
    output logic              pos_val_o,
    input  logic              pos_ready_i,
    output logic [WIDTH-1:0]  pos_o,
    output logic [IDX_W-1:0]  pos_idx_o,
    output logic              pos_last_o
);

    localparam int unsigned CNT_W = IDX_W + 1;

    typedef enum logic [0:0] {IDLE, SCAN} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  work_q, work_d;
    logic              msb_q, msb_d;
    logic              accept;
    logic [WIDTH-1:0]  beat_d;
    logic              last_d;
    logic [WIDTH-1:0]  enc_left_d, enc_right_d;

    function automatic logic [WIDTH-1:0] msb_oh(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (x[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] lsb_oh(input logic [WIDTH-1:0] x);
        return x & (~x + WIDTH'(1));
    endfunction

    function automatic logic [IDX_W-1:0] oh_idx(input logic [WIDTH-1:0] x);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (x[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] popcnt(input logic [WIDTH-1:0] x);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            c = c + CNT_W'(x[i]);
        end
        return c;
    endfunction

    // State register
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // Next state, working register update and next beat selection
    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        msb_d       = msb_q;
        accept      = 1'b0;
        enc_left_d  = msb_oh(data_i);
        enc_right_d = lsb_oh(data_i);
        case (state_q)
            IDLE: begin
                if (data_val_i && data_ready_o) begin
                    accept = 1'b1;
                    if (|data_i) begin
                        state_d = SCAN;
                        work_d  = data_i;
                        msb_d   = msb_first_i;
                    end
                end
            end
            SCAN: begin
                if (pos_ready_i) begin
                    work_d = work_q & ~pos_o;
                    if (pos_last_o) begin
                        state_d = IDLE;
                        work_d  = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                work_d  = '0;
            end
        endcase
        beat_d = msb_d ? msb_oh(work_d) : lsb_oh(work_d);
        last_d = (|work_d) && ((work_d & (work_d - WIDTH'(1))) == '0);
    end

    // Registered datapath and outputs
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            work_q       <= '0;
            msb_q        <= 1'b0;
            data_ready_o <= 1'b0;
            enc_val_o    <= 1'b0;
            data_left_o  <= '0;
            data_right_o <= '0;
            left_idx_o   <= '0;
            right_idx_o  <= '0;
            cnt_o        <= '0;
            zero_o       <= 1'b0;
            pos_val_o    <= 1'b0;
            pos_o        <= '0;
            pos_idx_o    <= '0;
            pos_last_o   <= 1'b0;
        end else begin
            work_q       <= work_d;
            msb_q        <= msb_d;
            data_ready_o <= (state_d == IDLE);
            enc_val_o    <= accept;
            if (accept) begin
                data_left_o  <= enc_left_d;
                data_right_o <= enc_right_d;
                left_idx_o   <= oh_idx(enc_left_d);
                right_idx_o  <= oh_idx(enc_right_d);
                cnt_o        <= popcnt(data_i);
                zero_o       <= ~|data_i;
            end
            pos_val_o  <= (state_d == SCAN);
            pos_o      <= (state_d == SCAN) ? beat_d : '0;
            pos_idx_o  <= (state_d == SCAN) ? oh_idx(beat_d) : '0;
            pos_last_o <= (state_d == SCAN) && last_d;
        end
    end

endmodule

// File: tb/tb_priority_encoder_stream.sv
// Scoreboard bench: stimulus pushes expected encode results and beats,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_priority_encoder_stream;

    typedef struct {
        logic [15:0] left;
        logic [15:0] right;
        logic [3:0]  lidx;
        logic [3:0]  ridx;
        logic [4:0]  cnt;
        logic        zero;
    } enc_exp_t;

    typedef struct {
        logic [3:0] idx;
        logic       last;
    } beat_exp_t;

    logic        clk_i = 1'b0;
    logic        arst_n_i;
    logic [15:0] data_i;
    logic        data_val_i;
    logic        msb_first_i;
    logic        data_ready_o;
    logic        enc_val_o;
    logic [15:0] data_left_o, data_right_o;
    logic [3:0]  left_idx_o, right_idx_o;
    logic [4:0]  cnt_o;
    logic        zero_o;
    logic        pos_val_o;
    logic        pos_ready_i;
    logic [15:0] pos_o;
    logic [3:0]  pos_idx_o;
    logic        pos_last_o;

    int errors = 0;
    int checks = 0;

    enc_exp_t  enc_q[$];
    beat_exp_t beat_q[$];

    priority_encoder_stream #(.WIDTH(16)) dut (
        .clk_i        (clk_i),
        .arst_n_i     (arst_n_i),
        .data_i       (data_i),
        .data_val_i   (data_val_i),
        .msb_first_i  (msb_first_i),
        .data_ready_o (data_ready_o),
        .enc_val_o    (enc_val_o),
        .data_left_o  (data_left_o),
        .data_right_o (data_right_o),
        .left_idx_o   (left_idx_o),
        .right_idx_o  (right_idx_o),
        .cnt_o        (cnt_o),
        .zero_o       (zero_o),
        .pos_val_o    (pos_val_o),
        .pos_ready_i  (pos_ready_i),
        .pos_o        (pos_o),
        .pos_idx_o    (pos_idx_o),
        .pos_last_o   (pos_last_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard
    logic        holding = 1'b0;
    logic        want_ready = 1'b0;
    logic [15:0] h_oh;
    logic [3:0]  h_idx;
    logic        h_last;
    enc_exp_t    last_enc = '{16'h0, 16'h0, 4'h0, 4'h0, 5'h0, 1'b0};

    initial begin
        enc_exp_t    e;
        beat_exp_t   b;
        logic [15:0] one;
        one = 16'h0001;
        forever begin
            @(negedge clk_i);
            if (!arst_n_i) begin
                holding    = 1'b0;
                want_ready = 1'b0;
                last_enc   = '{16'h0, 16'h0, 4'h0, 4'h0, 5'h0, 1'b0};
            end else begin
                if (want_ready) begin
                    check("ready_after_last", 64'(data_ready_o), 64'(1));
                    want_ready = 1'b0;
                end
                if (enc_val_o) begin
                    check("enc_expected", 64'(enc_q.size() > 0), 64'(1));
                    if (enc_q.size() > 0) begin
                        e = enc_q.pop_front();
                        check("enc_left",  64'(data_left_o),  64'(e.left));
                        check("enc_right", 64'(data_right_o), 64'(e.right));
                        check("enc_lidx",  64'(left_idx_o),   64'(e.lidx));
                        check("enc_ridx",  64'(right_idx_o),  64'(e.ridx));
                        check("enc_cnt",   64'(cnt_o),        64'(e.cnt));
                        check("enc_zero",  64'(zero_o),       64'(e.zero));
                        last_enc = e;
                    end
                end else begin
                    check("enc_hold",
                          64'({data_left_o, data_right_o, left_idx_o, right_idx_o, cnt_o, zero_o}),
                          64'({last_enc.left, last_enc.right, last_enc.lidx, last_enc.ridx,
                               last_enc.cnt, last_enc.zero}));
                end
                if (pos_val_o) begin
                    check("ready_low_in_scan", 64'(data_ready_o), 64'(0));
                    if (holding) begin
                        check("hold_idx",  64'(pos_idx_o),  64'(h_idx));
                        check("hold_oh",   64'(pos_o),      64'(h_oh));
                        check("hold_last", 64'(pos_last_o), 64'(h_last));
                    end
                    if (pos_ready_i) begin
                        holding = 1'b0;
                        check("beat_expected", 64'(beat_q.size() > 0), 64'(1));
                        if (beat_q.size() > 0) begin
                            b = beat_q.pop_front();
                            check("beat_idx",  64'(pos_idx_o),  64'(b.idx));
                            check("beat_oh",   64'(pos_o),      64'(one << b.idx));
                            check("beat_last", 64'(pos_last_o), 64'(b.last));
                            if (pos_last_o) want_ready = 1'b1;
                        end
                    end else begin
                        holding = 1'b1;
                        h_idx   = pos_idx_o;
                        h_oh    = pos_o;
                        h_last  = pos_last_o;
                    end
                end else begin
                    holding = 1'b0;
                    check("idle_pos_zero", 64'({pos_o, pos_idx_o, pos_last_o}), 64'(0));
                end
            end
        end
    end

    task automatic push_beat(input logic [3:0] idx, input logic last);
        beat_q.push_back('{idx, last});
    endtask

    task automatic accept(input logic [15:0] w, input logic msb,
                          input logic [15:0] l, input logic [15:0] r,
                          input logic [3:0] li, input logic [3:0] ri, input logic [4:0] c);
        int n = 0;
        while (!data_ready_o && n < 100) begin
            @(posedge clk_i); #1;
            n++;
        end
        check("ready_before_accept", 64'(data_ready_o), 64'(1));
        enc_q.push_back('{l, r, li, ri, c, (c == 5'd0)});
        data_i      = w;
        msb_first_i = msb;
        data_val_i  = 1'b1;
        @(posedge clk_i); #1;
        data_val_i = 1'b0;
        data_i     = '0;
        check("ready_after_accept", 64'(data_ready_o), 64'(w == 16'h0));
    endtask

    task automatic run_word(input bit toggle, input int budget);
        int n = 0;
        while ((beat_q.size() != 0 || !data_ready_o) && n < budget) begin
            pos_ready_i = toggle ? (n % 2 == 0) : 1'b1;
            @(posedge clk_i); #1;
            n++;
        end
        pos_ready_i = 1'b1;
        check("word_done_in_budget", 64'(n < budget), 64'(1));
    endtask

    task automatic check_all_zero(input string name);
        check(name, 64'({enc_val_o, pos_val_o, pos_last_o, zero_o, cnt_o, left_idx_o,
                         right_idx_o, pos_idx_o}), 64'(0));
        check({name, "_onehots"}, 64'({data_left_o, data_right_o, pos_o}), 64'(0));
    endtask

    initial begin
        arst_n_i    = 1'b0;
        data_i      = '0;
        data_val_i  = 1'b0;
        msb_first_i = 1'b0;
        pos_ready_i = 1'b1;

        // Reset behaviour
        #3;
        check("reset_ready", 64'(data_ready_o), 64'(0));
        check_all_zero("reset_outputs");
        repeat (2) @(posedge clk_i);
        #2;
        check("reset_ready_clocked", 64'(data_ready_o), 64'(0));
        @(negedge clk_i);
        arst_n_i = 1'b1;
        #1;
        check("ready_before_first_edge", 64'(data_ready_o), 64'(0));
        @(posedge clk_i); #1;
        check("ready_first_edge", 64'(data_ready_o), 64'(1));

        // 0x0840 MSB-first
        push_beat(4'd11, 1'b0);
        push_beat(4'd6,  1'b1);
        accept(16'h0840, 1'b1, 16'h0800, 16'h0040, 4'd11, 4'd6, 5'd2);
        run_word(1'b0, 100);

        // 0x0840 LSB-first
        push_beat(4'd6,  1'b0);
        push_beat(4'd11, 1'b1);
        accept(16'h0840, 1'b0, 16'h0800, 16'h0040, 4'd11, 4'd6, 5'd2);
        run_word(1'b0, 100);

        // single-bit word
        push_beat(4'd0, 1'b1);
        accept(16'h0001, 1'b1, 16'h0001, 16'h0001, 4'd0, 4'd0, 5'd1);
        run_word(1'b0, 100);

        // 0x2400 MSB-first
        push_beat(4'd13, 1'b0);
        push_beat(4'd10, 1'b1);
        accept(16'h2400, 1'b1, 16'h2000, 16'h0400, 4'd13, 4'd10, 5'd2);
        run_word(1'b0, 100);

        // zero word
        accept(16'h0000, 1'b1, 16'h0000, 16'h0000, 4'd0, 4'd0, 5'd0);
        repeat (3) @(posedge clk_i);
        #1;
        check("zero_word_ready", 64'(data_ready_o), 64'(1));

        // full word LSB-first, toggling back-pressure
        for (int i = 0; i < 16; i++) push_beat(4'(i), i == 15);
        accept(16'hFFFF, 1'b0, 16'h8000, 16'h0001, 4'd15, 4'd0, 5'd16);
        run_word(1'b1, 200);

        // 0x8001 with three stalled cycles and an ignored word during SCAN
        push_beat(4'd15, 1'b0);
        push_beat(4'd0,  1'b1);
        pos_ready_i = 1'b0;
        accept(16'h8001, 1'b1, 16'h8000, 16'h0001, 4'd15, 4'd0, 5'd2);
        @(posedge clk_i); #1;
        data_i     = 16'h1234;
        data_val_i = 1'b1;
        @(posedge clk_i); #1;
        data_val_i = 1'b0;
        data_i     = '0;
        @(posedge clk_i); #1;
        run_word(1'b0, 100);

        // 0x00F0, reset after the first beat
        pos_ready_i = 1'b1;
        push_beat(4'd7, 1'b0);
        accept(16'h00F0, 1'b1, 16'h0080, 16'h0010, 4'd7, 4'd4, 5'd4);
        @(posedge clk_i);
        #2;
        arst_n_i = 1'b0;
        #1;
        check("midscan_reset_ready", 64'(data_ready_o), 64'(0));
        check_all_zero("midscan_reset");
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        arst_n_i = 1'b1;
        @(posedge clk_i); #1;
        check("post_reset_ready", 64'(data_ready_o), 64'(1));
        check_all_zero("post_reset");
        repeat (20) @(posedge clk_i);
        #1;
        check("post_reset_quiet", 64'({pos_val_o, data_ready_o}), 64'(1));

        repeat (3) @(posedge clk_i);
        check("enc_queue_drained",  64'(enc_q.size()),  64'(0));
        check("beat_queue_drained", 64'(beat_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
